mer_sweep_controller: RTL and testbench
=======================================

# mer_sweep_controller

Sequencer for the symbol-rate MER measurement channel model. It drives `isi_power` into the channel model across a sweep of halving ISI levels. At each level it waits for the channel pipeline to flush, then accumulates error power and reference (errorless) signal power over 2^LOG2_N symbols. Each result is presented to a downstream logger through a valid/ready handshake. It sits between the stimulus source/logger and the channel-model DUT, and runs entirely on the system clock with the symbol-rate enable.

## Interface
Parameters:
- DATA_WIDTH, 18, width of `isi_power`, `error_in`, `ref_in` (signed 1sN-1 format)
- LOG2_N, 10, log2 of symbols accumulated per step
- SETTLE, 4, symbol enables discarded after each `isi_power` change (≥1)
- NUM_STEPS, 4, number of sweep steps (≥1, ≤16)
- ACC_W, 2*DATA_WIDTH-1+LOG2_N, accumulator width (derived; do not override)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- sym_en  in  1  symbol-rate clock enable, one-cycle pulse
- start  in  1  one-cycle request to begin a sweep
- isi_start  in  DATA_WIDTH signed  ISI level for step 0
- error_in  in  DATA_WIDTH signed  channel error sample
- ref_in  in  DATA_WIDTH signed  errorless decision variable
- isi_power  out  DATA_WIDTH signed  ISI level to the channel model
- busy  out  1  sweep in progress
- step_idx  out  4  current step number
- err_acc  out  ACC_W unsigned  sum of error_in² for the step
- sig_acc  out  ACC_W unsigned  sum of ref_in² for the step
- result_valid  out  1  err_acc/sig_acc/step_idx are final
- result_ready  in  1  downstream accepts the result
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- States: IDLE, SETTLE, ACCUM, REPORT.
- IDLE: `busy`=0 and `isi_power`=0.
  - `start`=1 → SETTLE, with step_idx=0, isi_power=isi_start, accumulators and counter cleared, busy=1.
  - A `sym_en` in the same cycle as `start` is not counted.
- SETTLE: count `sym_en` pulses. On the SETTLE-th pulse → ACCUM with the counter cleared. Inputs are ignored.
- ACCUM: on each `sym_en`, err_acc += error_in², sig_acc += ref_in², counter++. The squares are computed from inputs sampled in the `sym_en` cycle. On the 2^LOG2_N-th sample → REPORT.
- REPORT:
  - result_valid=1; all outputs hold and `sym_en` is ignored.
  - On result_valid & result_ready, if step_idx==NUM_STEPS-1: go to IDLE, pulse done, busy=0.
  - Otherwise: step_idx++, isi_power = isi_start >>> (step_idx+1) (arithmetic), accumulators cleared, → SETTLE.
- `start` is ignored while busy.
- Arithmetic:
  - Squares are exact, max 2^(2·DATA_WIDTH-2).
  - Accumulators are unsigned ACC_W bits and provably cannot overflow; no saturation.
- Reset (asynchronous, any state): state=IDLE. All outputs are 0: isi_power, busy, step_idx, err_acc, sig_acc, result_valid, done. Counters are also 0.

## Timing
- All outputs are registered.
- isi_power changes on the same edge that enters SETTLE.
- result_valid rises on the edge that accumulates the last sample.
- The handshake completes on the edge where result_valid & result_ready. result_valid drops on that edge.
- done is high for exactly the one cycle after the final handshake edge.
- result_ready may be held high continuously; in that case REPORT lasts exactly one cycle.
- Per-step latency, from entering SETTLE to result_valid, is (SETTLE + 2^LOG2_N) `sym_en` pulses. No sample is taken before the SETTLE-th pulse.
- Reset mid-step aborts with no result or done. A `start` after reset begins again at step 0.

## Test plan
Bench parameters: DATA_WIDTH=18, LOG2_N=2, SETTLE=2, NUM_STEPS=2, with sym_en every 16 clk.
- Reset: assert reset with random inputs → all outputs 0, and `start` is ignored while reset is low.
- Basic step:
  - Stimulus: isi_start=9268, error_in=1000, ref_in=-2000, pulse start.
  - Expected: isi_power=9268 and busy=1 immediately.
  - Expected: after 2 discarded + 4 counted sym_en, result_valid=1 with err_acc=4000000, sig_acc=16000000, step_idx=0.
- Backpressure:
  - Stimulus: hold result_ready=0 for 100 clk while sym_en continues.
  - Expected: outputs stable and accumulators unchanged.
  - Then raise result_ready → next cycle result_valid=0, step_idx=1, isi_power=4634, err_acc=sig_acc=0.
- Sweep end:
  - Stimulus: accept the step-1 result.
  - Expected: done=1 for one cycle, busy=0, isi_power=0.
  - A `start` pulsed mid-sweep has no effect.
- Extremes: error_in=ref_in=-131072 for all samples → err_acc=sig_acc=68719476736 (2^36), with no wrap in the 37-bit accumulators.
- Abort and corner case:
  - Reset pulsed during ACCUM → all outputs 0 and no done. A new start yields step 0 results identical to the basic step case.
  - `start` coincident with sym_en → that pulse is not counted toward SETTLE.

Source files
------------

// File: rtl/mer_sweep_controller.sv
// rtl/mer_sweep_controller.sv - ISI sweep sequencer accumulating error and reference power per step
module mer_sweep_controller #(
    parameter int DATA_WIDTH = 18,
    parameter int LOG2_N     = 10,
    parameter int SETTLE     = 4,
    parameter int NUM_STEPS  = 4,
    parameter int ACC_W      = 2*DATA_WIDTH-1+LOG2_N
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sym_en,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] isi_start,
    input  logic signed [DATA_WIDTH-1:0] error_in,
    input  logic signed [DATA_WIDTH-1:0] ref_in,
    output logic signed [DATA_WIDTH-1:0] isi_power,
    output logic                         busy,
    output logic [3:0]                   step_idx,
    output logic [ACC_W-1:0]             err_acc,
    output logic [ACC_W-1:0]             sig_acc,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         done
);

    localparam int NSAMP   = 1 << LOG2_N;
    localparam int CNT_MAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SQ_W    = 2*DATA_WIDTH-1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_REPORT} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [3:0]                    step_q, step_d;
    logic signed [DATA_WIDTH-1:0]  isi_base_q, isi_base_d;
    logic signed [DATA_WIDTH-1:0]  isi_q, isi_d;
    logic [ACC_W-1:0]              err_q, err_d;
    logic [ACC_W-1:0]              sig_q, sig_d;
    logic                          busy_q, busy_d;
    logic                          valid_q, valid_d;
    logic                          done_q, done_d;

    // Operands are sign-extended to the square width so the product is exact at SQ_W bits.
    logic signed [SQ_W-1:0] err_ext, ref_ext;
    logic [SQ_W-1:0]        err_sq, ref_sq;
    assign err_ext = SQ_W'(error_in);
    assign ref_ext = SQ_W'(ref_in);
    assign err_sq  = err_ext * err_ext;
    assign ref_sq  = ref_ext * ref_ext;

    logic settle_last, accum_last, last_step;
    assign settle_last = (cnt_q == CNT_W'(SETTLE - 1));
    assign accum_last  = (cnt_q == CNT_W'(NSAMP - 1));
    assign last_step   = (step_q == 4'(NUM_STEPS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            step_q     <= '0;
            isi_base_q <= '0;
            isi_q      <= '0;
            err_q      <= '0;
            sig_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            isi_base_q <= isi_base_d;
            isi_q      <= isi_d;
            err_q      <= err_d;
            sig_q      <= sig_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (sym_en && settle_last) state_d = S_ACCUM;
            S_ACCUM:  if (sym_en && accum_last) state_d = S_REPORT;
            S_REPORT: if (result_ready) state_d = last_step ? S_IDLE : S_SETTLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        step_d     = step_q;
        isi_base_d = isi_base_q;
        isi_d      = isi_q;
        err_d      = err_q;
        sig_d      = sig_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A sym_en coincident with start is deliberately not counted.
                if (start) begin
                    cnt_d      = '0;
                    step_d     = '0;
                    isi_base_d = isi_start;
                    isi_d      = isi_start;
                    err_d      = '0;
                    sig_d      = '0;
                    busy_d     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (sym_en) cnt_d = settle_last ? '0 : cnt_q + 1'b1;
            end
            S_ACCUM: begin
                if (sym_en) begin
                    err_d = err_q + ACC_W'(err_sq);
                    sig_d = sig_q + ACC_W'(ref_sq);
                    cnt_d = accum_last ? '0 : cnt_q + 1'b1;
                    if (accum_last) valid_d = 1'b1;
                end
            end
            S_REPORT: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    if (last_step) begin
                        busy_d = 1'b0;
                        isi_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        step_d = step_q + 4'd1;
                        isi_d  = isi_base_q >>> (step_q + 4'd1);
                        err_d  = '0;
                        sig_d  = '0;
                        cnt_d  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign isi_power    = isi_q;
    assign busy         = busy_q;
    assign step_idx     = step_q;
    assign err_acc      = err_q;
    assign sig_acc      = sig_q;
    assign result_valid = valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mer_sweep_controller.sv
// tb/tb_mer_sweep_controller.sv - scoreboard bench for mer_sweep_controller
module tb_mer_sweep_controller;

    localparam int DW     = 18;
    localparam int L2N    = 2;
    localparam int NS     = 1 << L2N;
    localparam int SET    = 2;
    localparam int STEPS  = 2;
    localparam int AW     = 2*DW-1+L2N;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sym_en = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] isi_start = '0;
    logic signed [DW-1:0] error_in = '0;
    logic signed [DW-1:0] ref_in = '0;
    logic signed [DW-1:0] isi_power;
    logic                 busy;
    logic [3:0]           step_idx;
    logic [AW-1:0]        err_acc;
    logic [AW-1:0]        sig_acc;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    logic                 done;

    mer_sweep_controller #(
        .DATA_WIDTH(DW), .LOG2_N(L2N), .SETTLE(SET), .NUM_STEPS(STEPS)
    ) dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .start(start),
        .isi_start(isi_start), .error_in(error_in), .ref_in(ref_in),
        .isi_power(isi_power), .busy(busy), .step_idx(step_idx),
        .err_acc(err_acc), .sig_acc(sig_acc), .result_valid(result_valid),
        .result_ready(result_ready), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     step;
        longint err;
        longint sig;
        longint isi;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rnd18();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic longint half_floor(input longint x);
        if (x < 0 && (x % 2) != 0) return x / 2 - 1;
        return x / 2;
    endfunction

    // Monitor: a result is consumed on any cycle where valid and ready are both high.
    always @(negedge clk) begin
        if (done) n_done++;
        if (reset && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got step %0d expected none", step_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_step", longint'(step_idx), longint'(e.step));
                chk("res_err",  longint'(err_acc),  e.err);
                chk("res_sig",  longint'(sig_acc),  e.sig);
                chk("res_isi",  longint'(isi_power), e.isi);
            end
        end
    end

    task automatic drive_random();
        error_in  = DW'(rnd18());
        ref_in    = DW'(rnd18());
    endtask

    task automatic pulse_sym(input int e, input int r);
        repeat (15) @(posedge clk);
        #1;
        sym_en   = 1'b1;
        error_in = DW'(e);
        ref_in   = DW'(r);
        @(posedge clk);
        #1;
        sym_en = 1'b0;
        drive_random();
    endtask

    task automatic do_start(input int isi, input bit with_sym);
        @(posedge clk);
        #1;
        isi_start = DW'(isi);
        start     = 1'b1;
        sym_en    = with_sym;
        drive_random();
        @(posedge clk);
        #1;
        start  = 1'b0;
        sym_en = 1'b0;
    endtask

    // Settle pulses carry random data that must be discarded; then NS counted samples.
    task automatic feed_step(input int step, input longint isi_exp,
                             input bit fixed, input int fe, input int fr);
        exp_t   x;
        longint se = 0, ss = 0;
        int     e, r;
        for (int i = 0; i < SET; i++) pulse_sym(rnd18(), rnd18());
        for (int i = 0; i < NS; i++) begin
            e = fixed ? fe : rnd18();
            r = fixed ? fr : rnd18();
            if (i == NS - 1) chk("valid_early", longint'(result_valid), 0);
            pulse_sym(e, r);
            se += longint'(e) * longint'(e);
            ss += longint'(r) * longint'(r);
        end
        x.step = step; x.err = se; x.sig = ss; x.isi = isi_exp;
        sb.push_back(x);
        @(negedge clk);
        chk("valid_rise", longint'(result_valid), 1);
    endtask

    task automatic accept();
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    initial begin
        int            isi_x;
        int            done_before;
        logic [AW-1:0] snap_err, snap_sig;
        logic [3:0]    snap_step;
        logic [DW-1:0] snap_isi;
        bit            stable;

        // Reset with random inputs and start requests
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start = 1'b1; sym_en = 1'($urandom_range(0, 1));
            isi_start = DW'(rnd18()); drive_random();
            @(negedge clk);
            chk("rst_isi", longint'(isi_power), 0);
            chk("rst_busy", longint'(busy), 0);
            chk("rst_acc", longint'(err_acc) + longint'(sig_acc) + longint'(step_idx), 0);
            chk("rst_valid_done", longint'(result_valid) + longint'(done), 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0; sym_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", longint'(busy), 0);

        // Basic step
        do_start(9268, 1'b0);
        @(negedge clk);
        chk("start_isi", longint'(isi_power), 9268);
        chk("start_busy", longint'(busy), 1);
        feed_step(0, 9268, 1'b1, 1000, -2000);
        chk("basic_err", longint'(err_acc), 4000000);
        chk("basic_sig", longint'(sig_acc), 16000000);

        // Backpressure with sym_en still running
        snap_err = err_acc; snap_sig = sig_acc; snap_step = step_idx; snap_isi = isi_power;
        stable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            sym_en = (c % 16 == 15);
            drive_random();
            @(negedge clk);
            if (err_acc !== snap_err || sig_acc !== snap_sig || step_idx !== snap_step ||
                isi_power !== snap_isi || result_valid !== 1'b1) stable = 1'b0;
        end
        sym_en = 1'b0;
        chk("bp_stable", longint'(stable), 1);
        accept();
        @(negedge clk);
        chk("hs_valid", longint'(result_valid), 0);
        chk("hs_step", longint'(step_idx), 1);
        chk("hs_isi", longint'(isi_power), 4634);
        chk("hs_acc_clr", longint'(err_acc) + longint'(sig_acc), 0);

        // Mid-sweep start is ignored
        do_start(rnd18(), 1'b0);
        @(negedge clk);
        chk("mid_start_step", longint'(step_idx), 1);
        chk("mid_start_isi", longint'(isi_power), 4634);
        feed_step(1, 4634, 1'b0, 0, 0);
        done_before = n_done;
        accept();
        @(negedge clk);
        chk("end_done", longint'(done), 1);
        chk("end_busy", longint'(busy), 0);
        chk("end_isi", longint'(isi_power), 0);
        @(negedge clk);
        chk("done_one_cycle", longint'(done), 0);
        chk("done_count1", longint'(n_done - done_before), 1);

        // Extremes, result_ready held high
        isi_x = rnd18();
        result_ready = 1'b1;
        do_start(isi_x, 1'b0);
        feed_step(0, longint'(isi_x), 1'b1, -131072, -131072);
        chk("ext_err", longint'(err_acc), 64'd68719476736);
        @(negedge clk);
        chk("report_one_cycle", longint'(result_valid), 0);
        feed_step(1, half_floor(longint'(isi_x)), 1'b1, -131072, -131072);
        @(negedge clk);
        chk("ext_done", longint'(done), 1);
        result_ready = 1'b0;

        // Reset during ACCUM aborts without result or done
        do_start(9268, 1'b0);
        for (int i = 0; i < SET + 2; i++) pulse_sym(rnd18(), rnd18());
        done_before = n_done;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out", longint'(isi_power) + longint'(busy) + longint'(step_idx) +
            longint'(err_acc) + longint'(sig_acc) + longint'(result_valid) + longint'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", longint'(n_done - done_before), 0);
        chk("abort_no_valid", longint'(result_valid), 0);

        // Restart with start coincident with sym_en
        do_start(9268, 1'b1);
        feed_step(0, 9268, 1'b1, 1000, -2000);
        accept();
        feed_step(1, 4634, 1'b0, 0, 0);
        accept();
        repeat (3) @(negedge clk);

        chk("sb_empty", longint'(sb.size()), 0);
        chk("done_total", longint'(n_done), 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
